// File: rtl/lp805x_schedfs_pg.sv
// lp805x_schedfs_pg: prescaler level selector for the frequency-scaling scheduler.
// On start it samples a demand factor and finds the slowest prescaler level whose
// power-of-two threshold (TOP_SCALE >> level) still covers the scaled demand, using
// either a linear (top-down) or a fixed-latency binary search.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start, mode, factor  request; mode 0 = linear, 1 = binary; sampled in IDLE only
//   busy                 search in progress
//   done                 one-cycle pulse when index/over/changed are updated
//   index                selected level, held between searches
//   over                 no level satisfied the demand (index forced to 0)
//   changed              pulse with done when the new index differs from the old one
module lp805x_schedfs_pg #(
  parameter int unsigned LEVELS       = 8,
  parameter int unsigned IDX_W        = 3,
  parameter int unsigned FACTOR_W     = 9,
  parameter int unsigned FACTOR_SHIFT = 4,
  parameter int unsigned TOP_SCALE    = 1600,
  parameter int unsigned SCALE_W      = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [FACTOR_W-1:0] factor,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    index,
  output logic                over,
  output logic                changed
);

  localparam int unsigned S_W   = FACTOR_W + FACTOR_SHIFT;
  localparam int unsigned CMP_W = (S_W > SCALE_W) ? S_W : SCALE_W;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned CNT_W = (IDX_W > 1) ? $clog2(IDX_W) : 1;
  localparam logic [IDX_W-1:0] LAST_LVL = IDX_W'(LEVELS - 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IDX_W - 1);

  typedef enum logic [1:0] {IDLE, LIN, BIN, DONE} state_t;

  state_t              state;
  logic [FACTOR_W-1:0] factor_q;
  logic [IDX_W-1:0]    cur;       // linear candidate, or lo bound in binary mode
  logic [IDX_W-1:0]    hi;
  logic [CNT_W-1:0]    iter;

  logic [SUM_W-1:0]    mid_sum;
  logic [IDX_W-1:0]    mid;
  logic [IDX_W-1:0]    test_lvl;
  logic [CMP_W-1:0]    s_val;
  logic [CMP_W-1:0]    thr;
  logic                hit;

  // Single shared comparator: binary search probes mid, everything else probes cur.
  always_comb begin
    mid_sum  = SUM_W'(cur) + SUM_W'(hi) + SUM_W'(1);
    mid      = IDX_W'(mid_sum >> 1);
    test_lvl = (state == BIN) ? mid : cur;
    s_val    = CMP_W'(factor_q) << FACTOR_SHIFT;
    thr      = CMP_W'(SCALE_W'(TOP_SCALE)) >> test_lvl;
    hit      = (s_val <= thr);
  end

  // Search FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      factor_q <= '0;
      cur      <= '0;
      hi       <= '0;
      iter     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      index    <= '0;
      over     <= 1'b0;
      changed  <= 1'b0;
    end else begin
      done    <= 1'b0;
      changed <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            factor_q <= factor;
            busy     <= 1'b1;
            iter     <= '0;
            if (mode) begin
              state <= BIN;
              cur   <= '0;
              hi    <= LAST_LVL;
            end else begin
              state <= LIN;
              cur   <= LAST_LVL;
            end
          end
        end
        LIN: begin
          // Stop on first match from the top, or at level 0 (DONE re-tests it for over).
          if (hit || (cur == '0)) state <= DONE;
          else                    cur   <= cur - IDX_W'(1);
        end
        BIN: begin
          // Once the window collapses (lo == hi) the remaining iterations just idle.
          if (cur < hi) begin
            if (hit) cur <= mid;
            else     hi  <= mid - IDX_W'(1);
          end
          if (iter == LAST_ITER) state <= DONE;
          else                   iter  <= iter + CNT_W'(1);
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (hit) begin
            index   <= cur;
            over    <= 1'b0;
            changed <= (cur != index);
          end else begin
            index   <= '0;
            over    <= 1'b1;
            changed <= (index != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lp805x_schedfs_pg.sv
// Testbench for lp805x_schedfs_pg: scoreboard of expected results checked by a
// done-driven monitor against a behavioural model of the threshold table.
module tb_lp805x_schedfs_pg;

  localparam int unsigned LEVELS       = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned FACTOR_W     = 9;
  localparam int unsigned FACTOR_SHIFT = 4;
  localparam int unsigned TOP_SCALE    = 1600;
  localparam int unsigned SCALE_W      = 11;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                mode;
  logic [FACTOR_W-1:0] factor;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    index;
  logic                over;
  logic                changed;

  lp805x_schedfs_pg #(
    .LEVELS(LEVELS), .IDX_W(IDX_W), .FACTOR_W(FACTOR_W),
    .FACTOR_SHIFT(FACTOR_SHIFT), .TOP_SCALE(TOP_SCALE), .SCALE_W(SCALE_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .factor(factor),
    .busy(busy), .done(done), .index(index), .over(over), .changed(changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int ov;
    int chg;
    int lat;
    int t0;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   prev_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: largest level whose threshold covers the scaled demand.
  function automatic void model(input int f, input bit m, output int idx,
                                output int ov, output int lat);
    int unsigned s;
    int found;
    s = int'(f) * (1 << FACTOR_SHIFT);
    found = -1;
    for (int i = 0; i < int'(LEVELS); i++)
      if (s <= (TOP_SCALE / (1 << i))) found = i;
    idx = (found < 0) ? 0 : found;
    ov  = (found < 0) ? 1 : 0;
    lat = m ? int'(IDX_W) + 1 : (int'(LEVELS) - idx) + 1;
  endfunction

  // Monitor: every done pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("index",   int'(index),   e.idx);
        check("over",    int'(over),    e.ov);
        check("changed", int'(changed), e.chg);
        check("latency", cyc - e.t0,    e.lat);
      end
    end
  end

  // Issue one request; with hold, start stays high and inputs churn until done.
  task automatic issue(input bit m, input int f, input bit hold);
    int k;
    exp_t e;
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    if (busy) check("idle_timeout", 1, 0);
    start  = 1'b1;
    mode   = m;
    factor = FACTOR_W'(f);
    @(posedge clk);
    #1;
    model(f, m, e.idx, e.ov, e.lat);
    e.chg = (e.idx != prev_idx) ? 1 : 0;
    e.t0  = cyc;
    prev_idx = e.idx;
    q.push_back(e);
    @(negedge clk);
    check("busy_during_search", int'(busy), 1);
    if (!hold) begin
      start  = 1'b0;
      mode   = ~m;
      factor = FACTOR_W'($urandom);
    end else begin
      k = 0;
      while (!done && k < 50) begin
        factor = FACTOR_W'($urandom);
        mode   = 1'($urandom);
        @(negedge clk);
        k++;
      end
      start = 1'b0;
    end
    k = 0;
    while (q.size() != 0 && k < 50) begin @(negedge clk); k++; end
    if (q.size() != 0) begin
      check("done_timeout", 1, 0);
      q.delete();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; factor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_index", int'(index), 0);
    check("rst_over", int'(over), 0);
    check("rst_changed", int'(changed), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Directed cases.
    issue(1'b0, 0, 1'b0);
    issue(1'b0, 1, 1'b0);
    issue(1'b0, 1, 1'b0);
    issue(1'b0, 100, 1'b0);
    issue(1'b0, 101, 1'b0);
    issue(1'b1, 5, 1'b0);
    issue(1'b1, 101, 1'b0);
    issue(1'b1, 0, 1'b0);

    // start held high through the search, including the DONE cycle.
    issue(1'b1, 37, 1'b1);
    issue(1'b0, 3, 1'b1);
    repeat (4) @(negedge clk);

    // Full factor sweep in both modes.
    for (int f = 0; f < (1 << FACTOR_W); f++) begin
      issue(1'b0, f, 1'b0);
      issue(1'b1, f, 1'b0);
    end

    // Randomized requests with random gaps and occasional held start.
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << FACTOR_W) - 1)),
            ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a linear search.
    issue(1'b0, 1, 1'b0);
    start = 1'b1; mode = 1'b0; factor = FACTOR_W'(100);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_index", int'(index), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    prev_idx = 0;
    repeat (12) @(negedge clk);
    check("postrst_busy", int'(busy), 0);
    check("postrst_index", int'(index), 0);
    issue(1'b0, 100, 1'b0);
    issue(1'b1, 0, 1'b0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
